// File: rtl/network_tx_pkt_read.sv
// network_tx_pkt_read: reads a scheduled packet from buffer RAM, restores its TSNtag, streams it to the tx FIFO
module network_tx_pkt_read #(
    parameter int IFG_CYCLES = 3,
    parameter int MAX_WORDS  = 128
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [8:0]   iv_pkt_bufid,
    input  logic [47:0]  iv_tsntag,
    input  logic         i_pkt_bufid_wr,
    output logic         o_pkt_bufid_ack,
    output logic [15:0]  ov_pkt_raddr,
    output logic         o_pkt_rd,
    input  logic [133:0] iv_pkt_rdata,
    input  logic         i_pkt_rdata_wr,
    output logic [8:0]   ov_pkt_bufid_release,
    output logic         o_pkt_bufid_release_wr,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    input  logic         i_fifo_almost_full,
    output logic [1:0]   ov_ntx_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, DRAIN = 2'b10, IFG = 2'b11} state_t;
    localparam logic [7:0] MAX_W    = 8'(MAX_WORDS);
    localparam logic [6:0] LAST_IDX = 7'(MAX_WORDS - 1);
    localparam logic [7:0] IFG_LOAD = 8'(IFG_CYCLES);
    state_t         state_q;
    logic [8:0]     bufid_q;
    logic [47:0]    tsntag_q;
    logic [7:0]     word_idx_q;
    logic [6:0]     rx_idx_q;
    logic [3:0]     outstanding_q;
    logic [3:0]     outstanding_d;
    logic           tail_seen_q;
    logic [7:0]     ifg_q;
    logic [133:0]   data_q;
    logic           data_wr_q;
    logic [8:0]     release_q;
    logic           release_wr_q;
    logic           ack_q;
    logic           rd;
    logic           take;
    logic           fwd;
    logic           is_tail;
    logic [133:0]   word_d;
    assign rd            = state_q == READ && !i_fifo_almost_full && !tail_seen_q && word_idx_q < MAX_W;
    assign take          = i_pkt_rdata_wr && (state_q == READ || state_q == DRAIN);
    assign fwd           = take && !tail_seen_q;
    assign is_tail       = iv_pkt_rdata[133:132] == 2'b10 || rx_idx_q == LAST_IDX;
    assign outstanding_d = outstanding_q + {3'b0, rd} - {3'b0, take};
    assign o_pkt_rd               = rd;
    assign ov_pkt_raddr           = {bufid_q, word_idx_q[6:0]};
    assign o_pkt_bufid_ack        = ack_q;
    assign ov_pkt_bufid_release   = release_q;
    assign o_pkt_bufid_release_wr = release_wr_q;
    assign ov_data                = data_q;
    assign o_data_wr              = data_wr_q;
    assign ov_ntx_state           = state_q;
    // head word gets the latched tsntag; the last legal word of a tailless buffer is forced to tail
    always_comb begin
        word_d          = iv_pkt_rdata;
        word_d[127:80]  = iv_pkt_rdata[133:132] == 2'b01 ? tsntag_q : iv_pkt_rdata[127:80];
        word_d[133:132] = is_tail ? 2'b10 : iv_pkt_rdata[133:132];
    end
    // frame FSM, read/return bookkeeping and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            bufid_q       <= '0;
            tsntag_q      <= '0;
            word_idx_q    <= '0;
            rx_idx_q      <= '0;
            outstanding_q <= '0;
            tail_seen_q   <= 1'b0;
            ifg_q         <= '0;
            data_q        <= '0;
            data_wr_q     <= 1'b0;
            release_q     <= '0;
            release_wr_q  <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            data_wr_q     <= 1'b0;
            release_wr_q  <= 1'b0;
            ack_q         <= 1'b0;
            outstanding_q <= outstanding_d;
            if (rd) word_idx_q <= word_idx_q + 8'd1;
            if (fwd) begin
                data_q      <= word_d;
                data_wr_q   <= 1'b1;
                rx_idx_q    <= rx_idx_q + 7'd1;
                tail_seen_q <= is_tail;
            end
            case (state_q)
                IDLE: if (i_pkt_bufid_wr) begin
                    bufid_q       <= iv_pkt_bufid;
                    tsntag_q      <= iv_tsntag;
                    word_idx_q    <= '0;
                    rx_idx_q      <= '0;
                    outstanding_q <= '0;
                    tail_seen_q   <= 1'b0;
                    state_q       <= READ;
                end
                READ: if (tail_seen_q) state_q <= DRAIN;
                DRAIN: if (outstanding_q == 4'd0) begin
                    release_q    <= bufid_q;
                    release_wr_q <= 1'b1;
                    ifg_q        <= IFG_LOAD;
                    state_q      <= IFG;
                end
                default: begin
                    ifg_q <= ifg_q - 8'd1;
                    if (ifg_q == 8'd1) begin
                        ack_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
